// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - ALU_OP_* opcode constants (4-bit encoding understood by alu)
//   - arb_state_t: arbiter FSM state, also exported on a debug port
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_REG0 = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_REG1 = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOT  = 4'd7;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels of the two ALU requesters.
//
// Handshake rules (both request and response channels):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The source holds valid and payload stable until that edge; dropping
//   valid earlier withdraws the offer and nothing is transferred.
//
// Signals (per requester N = 0/1):
//   reqN_valid/reqN_ready/reqN_op/reqN_a/reqN_b  operation request channel
//   rspN_valid/rspN_ready                       result response channel
//   rsp_data                                    result, shared by both rsp channels
// Modports: slave = arbiter side, master = requester side.
interface alu_arbiter_if #(
  parameter int WORD_SIZE = 18
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [3:0]           req0_op;
  logic [WORD_SIZE-1:0] req0_a;
  logic [WORD_SIZE-1:0] req0_b;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [3:0]           req1_op;
  logic [WORD_SIZE-1:0] req1_a;
  logic [WORD_SIZE-1:0] req1_b;

  logic                 rsp0_valid;
  logic                 rsp0_ready;
  logic                 rsp1_valid;
  logic                 rsp1_ready;
  logic [WORD_SIZE-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data
  );

endinterface

// File: rtl/alu.sv
// alu: purely combinational datapath.
//   op     in  4          ALU_OP_* opcode; 8..15 yield 0
//   r0     in  WORD_SIZE  first operand
//   r1     in  WORD_SIZE  second operand
//   result out WORD_SIZE  ADD/SUB wrap modulo 2^WORD_SIZE, no carry out
module alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic [ALU_OP_W-1:0]  op,
  input  logic [WORD_SIZE-1:0] r0,
  input  logic [WORD_SIZE-1:0] r1,
  output logic [WORD_SIZE-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_OP_REG0: result = r0;
      ALU_OP_REG1: result = r1;
      ALU_OP_ADD:  result = r0 + r1;
      ALU_OP_SUB:  result = r0 - r1;
      ALU_OP_AND:  result = r0 & r1;
      ALU_OP_OR:   result = r0 | r1;
      ALU_OP_XOR:  result = r0 ^ r1;
      ALU_OP_NOT:  result = ~r1;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters, one op in flight.
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high
//   bus       slave modport of alu_arbiter_if (two req/rsp channel pairs)
//   busy      out  high whenever the FSM is not idle
//   state_dbg out  current FSM state
//   prio_dbg  out  requester that wins when both request together
// Flow: IDLE (grant + latch operands) -> EXEC (capture alu result)
//       -> RESP (hold result until the owner takes it) -> IDLE.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic       clk,
  input  logic       reset,
  alu_arbiter_if.slave bus,
  output logic       busy,
  output arb_state_t state_dbg,
  output logic       prio_dbg
);

  arb_state_t state_q, state_d;

  logic                 prio_q;
  logic                 owner_q;
  logic [ALU_OP_W-1:0]  op_q;
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] b_q;
  logic [WORD_SIZE-1:0] rsp_data_q;
  logic [WORD_SIZE-1:0] alu_result;

  logic win;        // 1 = requester 1 would be granted this cycle
  logic load_req;
  logic capture;
  logic rsp_done;
  logic req0_ready_c, req1_ready_c;
  logic rsp0_valid_c, rsp1_valid_c;

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .op     (op_q),
    .r0     (a_q),
    .r1     (b_q),
    .result (alu_result)
  );

  // Requester 1 wins when it is alone, or when both ask and prio points at it.
  assign win = bus.req1_valid && (!bus.req0_valid || prio_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load_req     = 1'b0;
    capture      = 1'b0;
    rsp_done     = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    rsp0_valid_c = 1'b0;
    rsp1_valid_c = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          req0_ready_c = !win;
          req1_ready_c = win;
          load_req     = 1'b1;
          state_d      = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        capture = 1'b1;
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        rsp0_valid_c = !owner_q;
        rsp1_valid_c = owner_q;
        // Only the owner's ready matters; the other channel is ignored.
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          rsp_done = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
    end else begin
      if (load_req) begin
        owner_q <= win;
        op_q    <= win ? bus.req1_op : bus.req0_op;
        a_q     <= win ? bus.req1_a  : bus.req0_a;
        b_q     <= win ? bus.req1_b  : bus.req0_b;
      end
      if (capture) rsp_data_q <= alu_result;
      // Fairness point: priority moves only when a response completes.
      if (rsp_done) prio_q <= ~owner_q;
    end
  end

  assign bus.req0_ready = req0_ready_c;
  assign bus.req1_ready = req1_ready_c;
  assign bus.rsp0_valid = rsp0_valid_c;
  assign bus.rsp1_valid = rsp1_valid_c;
  assign bus.rsp_data   = rsp_data_q;

  assign busy      = (state_q != ARB_IDLE);
  assign state_dbg = state_q;
  assign prio_dbg  = prio_q;

endmodule
